// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StDone
  } spi_state_e;

  localparam logic RwWrite = 1'b1;
  localparam logic RwRead  = 1'b0;

  function automatic int unsigned frame_w(int unsigned addr_w, int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with registered-history edge pulses.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~hist_q;
  assign fall_o = ~sync_o & hist_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral with read/write access to a bank of configuration registers.
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_valid,
  output logic                       frame_err
);

  localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CntFrame   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CntMax     = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CntCmdLast = CNT_W'(ADDR_W);

  logic ncs_sync, ncs_rise, ncs_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic unused_sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic copi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (nCS),
    .sync_o (ncs_sync),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SCLK),
    .sync_o (sclk_sync),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign unused_sclk_sync = sclk_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) copi_sync_q <= '0;
    else     copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
  end
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  // nCS events count only once the synchronised nCS has been seen high after reset,
  // so a chip select already low at reset release cannot start a frame.
  logic armed_q, armed_d;
  logic ncs_rise_ev, ncs_fall_ev;
  assign armed_d     = armed_q | ncs_sync;
  assign ncs_rise_ev = ncs_rise & armed_q;
  assign ncs_fall_ev = ncs_fall & armed_q;

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FRAME_W-1:0]  rx_q, rx_d, rx_shift;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                cipo_q, cipo_d;
  logic                rd_q, rd_d;
  logic                wr_valid_q, frame_err_q, err_d;
  logic                wr_en;
  logic [ADDR_W-1:0]   rd_addr, wr_addr;
  logic [DATA_W-1:0]   rd_data, wr_data;
  logic                wr_addr_ok;

  assign rx_shift   = {rx_q[FRAME_W-2:0], copi_s};
  assign rd_addr    = rx_shift[ADDR_W-1:0];
  assign wr_addr    = rx_q[FRAME_W-2 -: ADDR_W];
  assign wr_data    = rx_q[DATA_W-1:0];
  assign wr_addr_ok = ({1'b0, wr_addr} < (ADDR_W + 1)'(NUM_REGS));

  // Out-of-range addresses match no register and read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs_out[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rd_d    = rd_q;
    cipo_d  = (state_q == StData) ? cipo_q : 1'b0;
    wr_en   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ncs_fall_ev) begin
          state_d = StCmd;
          cnt_d   = '0;
          rx_d    = '0;
          rd_d    = 1'b0;
        end
      end
      StCmd: begin
        if (ncs_rise_ev) begin
          state_d = StDone;
        end else if (sclk_rise) begin
          rx_d  = rx_shift;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntCmdLast) begin
            state_d = StData;
            rd_d    = (rx_shift[ADDR_W] == RwRead);
            tx_d    = (rx_shift[ADDR_W] == RwRead) ? rd_data : '0;
          end
        end
      end
      StData: begin
        if (ncs_rise_ev) begin
          state_d = StDone;
          cipo_d  = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_d = rx_shift;
            if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
          end
          if (sclk_fall && rd_q) begin
            cipo_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (cnt_q == CntFrame) begin
          wr_en = (rx_q[FRAME_W-1] == RwWrite) && wr_addr_ok;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_q        <= 1'b0;
      cipo_q      <= 1'b0;
      armed_q     <= 1'b0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      cipo_q      <= cipo_d;
      armed_q     <= armed_d;
      wr_valid_q  <= wr_en;
      frame_err_q <= err_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg
    logic [DATA_W-1:0] reg_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                       reg_q <= '0;
      else if (wr_en && (wr_addr == ADDR_W'(g)))     reg_q <= wr_data;
    end
    assign regs_out[g*DATA_W +: DATA_W] = reg_q;
  end

  assign CIPO      = cipo_q;
  assign cipo_oe   = armed_q & ~ncs_sync;
  assign wr_valid  = wr_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Randomised bench for spi_regfile_peripheral: default and wide-parameter instances.
module tb_spi_regfile_peripheral;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic ncs0 = 1'b1, sclk0 = 1'b0, copi0 = 1'b0;
  logic cipo0, oe0, wv0, fe0;
  logic [39:0] regs0;
  logic ncs1 = 1'b1, sclk1 = 1'b0, copi1 = 1'b0;
  logic cipo1, oe1, wv1, fe1;
  logic [255:0] regs1;

  spi_regfile_peripheral u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .nCS       (ncs0),
    .SCLK      (sclk0),
    .COPI      (copi0),
    .CIPO      (cipo0),
    .cipo_oe   (oe0),
    .regs_out  (regs0),
    .wr_valid  (wv0),
    .frame_err (fe0)
  );

  spi_regfile_peripheral #(
    .NUM_REGS    (16),
    .ADDR_W      (4),
    .DATA_W      (16),
    .SYNC_STAGES (3)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .nCS       (ncs1),
    .SCLK      (sclk1),
    .COPI      (copi1),
    .CIPO      (cipo1),
    .cipo_oe   (oe1),
    .regs_out  (regs1),
    .wr_valid  (wv1),
    .frame_err (fe1)
  );

  int total = 0;
  int bad = 0;
  int wv_cnt0 = 0, fe_cnt0 = 0, wv_cnt1 = 0, fe_cnt1 = 0;

  always @(posedge clk) begin
    if (wv0) wv_cnt0 <= wv_cnt0 + 1;
    if (fe0) fe_cnt0 <= fe_cnt0 + 1;
    if (wv1) wv_cnt1 <= wv_cnt1 + 1;
    if (fe1) fe_cnt1 <= fe_cnt1 + 1;
  end

  logic [7:0]  m0 [5];
  logic [15:0] m1 [16];

  function automatic logic [39:0] exp0();
    logic [39:0] r;
    for (int i = 0; i < 5; i++) r[i*8 +: 8] = m0[i];
    return r;
  endfunction

  function automatic logic [255:0] exp1();
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = m1[i];
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 5; i++) m0[i] = '0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int d, input logic n, input logic s, input logic c);
    if (d == 0) begin
      ncs0 = n; sclk0 = s; copi0 = c;
    end else begin
      ncs1 = n; sclk1 = s; copi1 = c;
    end
  endtask

  // Expected behaviour of one frame, from the protocol rules alone.
  task automatic model_frame(input int d, input logic [31:0] f, input int nb,
                             output logic [31:0] erx, output int ewv, output int efe);
    int aw, dw, nr, addr, k;
    logic rw;
    logic [31:0] rdval;
    aw = (d == 0) ? 7 : 4;
    dw = (d == 0) ? 8 : 16;
    nr = (d == 0) ? 5 : 16;
    erx = '0; ewv = 0; efe = 0; rw = 1'b0; addr = 0; rdval = '0;
    if (nb >= 1 + aw) begin
      rw   = f[nb-1];
      addr = int'((f >> (nb - 1 - aw)) & ((32'd1 << aw) - 1));
      if (addr < nr) rdval = (d == 0) ? 32'(m0[addr]) : 32'(m1[addr]);
    end
    for (k = 0; k < nb; k++) begin
      erx = erx << 1;
      if (!rw && nb >= 1 + aw && k >= 1 + aw && (k - 1 - aw) < dw)
        erx[0] = rdval[dw - 1 - (k - 1 - aw)];
    end
    if (nb != 1 + aw + dw) begin
      efe = 1;
    end else if (rw && addr < nr) begin
      ewv = 1;
      if (d == 0) m0[addr] = f[7:0];
      else        m1[addr] = f[15:0];
    end
  endtask

  // Drives one frame and returns CIPO sampled just before each SCLK rise plus pulse counts.
  task automatic xfer(input int d, input logic [31:0] f, input int nb,
                      output logic [31:0] rx, output int dwv, output int dfe);
    int wv_b, fe_b;
    wv_b = (d == 0) ? wv_cnt0 : wv_cnt1;
    fe_b = (d == 0) ? fe_cnt0 : fe_cnt1;
    rx = '0;
    drive(d, 1'b0, 1'b0, 1'b0);
    wait_clk(H);
    for (int i = 0; i < nb; i++) begin
      drive(d, 1'b0, 1'b0, f[nb-1-i]);
      wait_clk(H);
      rx = {rx[30:0], (d == 0) ? cipo0 : cipo1};
      if (i == 0) begin
        total++;
        if (((d == 0) ? oe0 : oe1) !== 1'b1) begin
          bad++;
          $display("FAIL cipo_oe_active dut%0d got=%b exp=1", d, (d == 0) ? oe0 : oe1);
        end
      end
      drive(d, 1'b0, 1'b1, f[nb-1-i]);
      wait_clk(H);
    end
    drive(d, 1'b0, 1'b0, 1'b0);
    wait_clk(H);
    drive(d, 1'b1, 1'b0, 1'b0);
    wait_clk(12);
    dwv = ((d == 0) ? wv_cnt0 : wv_cnt1) - wv_b;
    dfe = ((d == 0) ? fe_cnt0 : fe_cnt1) - fe_b;
  endtask

  task automatic test_reset();
    total++;
    if (regs0 !== 40'h0) begin bad++; $display("FAIL reset_regs0 got=%h exp=0", regs0); end
    total++;
    if (regs1 !== 256'h0) begin bad++; $display("FAIL reset_regs1 got=%h exp=0", regs1); end
    total++;
    if ({cipo0, oe0, wv0, fe0} !== 4'b0) begin
      bad++; $display("FAIL reset_outs got=%b exp=0000", {cipo0, oe0, wv0, fe0});
    end
  endtask

  task automatic test_write();
    logic [31:0] rx, erx; int dwv, dfe, ewv, efe;
    model_frame(0, 32'h8455, 16, erx, ewv, efe);
    xfer(0, 32'h8455, 16, rx, dwv, dfe);
    total++;
    if (regs0 !== exp0()) begin bad++; $display("FAIL write_regs got=%h exp=%h", regs0, exp0()); end
    total++;
    if (regs0 !== 40'h55_0000_0000) begin
      bad++; $display("FAIL write_reg4 got=%h exp=5500000000", regs0);
    end
    total++;
    if (dwv !== 1 || dfe !== 0) begin
      bad++; $display("FAIL write_pulses got=wv%0d/fe%0d exp=wv1/fe0", dwv, dfe);
    end
    total++;
    if (rx !== erx) begin bad++; $display("FAIL write_cipo got=%h exp=%h", rx, erx); end
  endtask

  task automatic test_read();
    logic [31:0] rx, erx; int dwv, dfe, ewv, efe;
    model_frame(0, 32'h810A, 16, erx, ewv, efe);
    xfer(0, 32'h810A, 16, rx, dwv, dfe);
    model_frame(0, 32'h0100, 16, erx, ewv, efe);
    xfer(0, 32'h0100, 16, rx, dwv, dfe);
    total++;
    if (rx !== 32'h0000_000A) begin bad++; $display("FAIL read_cipo got=%h exp=0000000a", rx); end
    total++;
    if (dwv !== 0 || dfe !== 0) begin
      bad++; $display("FAIL read_pulses got=wv%0d/fe%0d exp=wv0/fe0", dwv, dfe);
    end
    total++;
    if (regs0 !== exp0()) begin bad++; $display("FAIL read_regs got=%h exp=%h", regs0, exp0()); end
  endtask

  task automatic test_bad_length();
    logic [31:0] rx, erx; int dwv, dfe, ewv, efe;
    int lens [2] = '{15, 17};
    for (int j = 0; j < 2; j++) begin
      model_frame(0, 32'h8433 >> (16 - lens[j]), lens[j], erx, ewv, efe);
      xfer(0, 32'h8433 >> (16 - lens[j]), lens[j], rx, dwv, dfe);
      total++;
      if (dfe !== 1 || dwv !== 0) begin
        bad++; $display("FAIL badlen%0d_pulses got=wv%0d/fe%0d exp=wv0/fe1", lens[j], dwv, dfe);
      end
      total++;
      if (regs0 !== exp0()) begin
        bad++; $display("FAIL badlen%0d_regs got=%h exp=%h", lens[j], regs0, exp0());
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rx, erx; int dwv, dfe, ewv, efe;
    model_frame(0, 32'hFF5A, 16, erx, ewv, efe);
    xfer(0, 32'hFF5A, 16, rx, dwv, dfe);
    total++;
    if (dwv !== 0 || dfe !== 0) begin
      bad++; $display("FAIL oor_write_pulses got=wv%0d/fe%0d exp=wv0/fe0", dwv, dfe);
    end
    total++;
    if (regs0 !== exp0()) begin bad++; $display("FAIL oor_write_regs got=%h exp=%h", regs0, exp0()); end
    model_frame(0, 32'h7F00, 16, erx, ewv, efe);
    xfer(0, 32'h7F00, 16, rx, dwv, dfe);
    total++;
    if (rx !== 32'h0) begin bad++; $display("FAIL oor_read_cipo got=%h exp=0", rx); end
  endtask

  task automatic test_random();
    logic [31:0] f, rx, erx; int dwv, dfe, ewv, efe, nb;
    for (int it = 0; it < 24; it++) begin
      f  = {16'h0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
      nb = 16;
      if ($urandom_range(0, 5) == 0) begin
        nb = ($urandom_range(0, 1) == 1) ? 17 : 15;
        f  = (nb == 17) ? {f[30:0], 1'($urandom)} : (f >> 1);
      end
      model_frame(0, f, nb, erx, ewv, efe);
      xfer(0, f, nb, rx, dwv, dfe);
      total++;
      if (rx !== erx) begin bad++; $display("FAIL rand%0d_cipo got=%h exp=%h", it, rx, erx); end
      total++;
      if (dwv !== ewv || dfe !== efe) begin
        bad++;
        $display("FAIL rand%0d_pulses got=wv%0d/fe%0d exp=wv%0d/fe%0d", it, dwv, dfe, ewv, efe);
      end
      total++;
      if (regs0 !== exp0()) begin
        bad++; $display("FAIL rand%0d_regs got=%h exp=%h", it, regs0, exp0());
      end
    end
  endtask

  task automatic test_params();
    logic [31:0] f, rx, erx; int dwv, dfe, ewv, efe;
    f = {11'h0, 1'b1, 4'hF, 16'hBEEF};
    model_frame(1, f, 21, erx, ewv, efe);
    xfer(1, f, 21, rx, dwv, dfe);
    total++;
    if (regs1 !== exp1()) begin bad++; $display("FAIL param_write_regs got=%h exp=%h", regs1, exp1()); end
    total++;
    if (dwv !== 1 || dfe !== 0) begin
      bad++; $display("FAIL param_write_pulses got=wv%0d/fe%0d exp=wv1/fe0", dwv, dfe);
    end
    for (int it = 0; it < 4; it++) begin
      f = {11'h0, 1'b1, 4'($urandom_range(0, 14)), 16'($urandom)};
      model_frame(1, f, 21, erx, ewv, efe);
      xfer(1, f, 21, rx, dwv, dfe);
    end
    f = {11'h0, 1'b0, 4'hF, 16'h0};
    model_frame(1, f, 21, erx, ewv, efe);
    xfer(1, f, 21, rx, dwv, dfe);
    total++;
    if (rx !== 32'h0000_BEEF) begin bad++; $display("FAIL param_read_cipo got=%h exp=0000beef", rx); end
    total++;
    if (regs1 !== exp1()) begin bad++; $display("FAIL param_regs got=%h exp=%h", regs1, exp1()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rx, erx; int dwv, dfe, ewv, efe, fe_b;
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_clk(H);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b0, 1'b0, 1'b1);
      wait_clk(H);
      drive(0, 1'b0, 1'b1, 1'b1);
      wait_clk(H);
    end
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_clk(2);
    rst = 1'b1;
    #1;
    total++;
    if ({regs0, cipo0, oe0, wv0, fe0} !== 44'h0) begin
      bad++; $display("FAIL midrst_outs got=%h exp=0", {regs0, cipo0, oe0, wv0, fe0});
    end
    total++;
    if (regs1 !== 256'h0) begin bad++; $display("FAIL midrst_regs1 got=%h exp=0", regs1); end
    clear_model();
    wait_clk(3);
    rst = 1'b0;
    fe_b = fe_cnt0;
    wait_clk(20);
    total++;
    if (oe0 !== 1'b0) begin bad++; $display("FAIL midrst_oe_held got=%b exp=0", oe0); end
    drive(0, 1'b1, 1'b0, 1'b0);
    wait_clk(20);
    total++;
    if (fe_cnt0 - fe_b !== 0) begin
      bad++; $display("FAIL midrst_no_frame got=fe%0d exp=fe0", fe_cnt0 - fe_b);
    end
    model_frame(0, 32'h82C3, 16, erx, ewv, efe);
    xfer(0, 32'h82C3, 16, rx, dwv, dfe);
    total++;
    if (regs0 !== exp0() || dwv !== 1) begin
      bad++; $display("FAIL midrst_rewrite got=%h/wv%0d exp=%h/wv1", regs0, dwv, exp0());
    end
  endtask

  initial begin
    clear_model();
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);
    test_reset();
    test_write();
    test_read();
    test_bad_length();
    test_out_of_range();
    test_random();
    test_params();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

Parametrised SPI mode-0 peripheral giving an external controller write and read access to a bank of `NUM_REGS` configuration registers. It is the successor to the fixed five-register, write-only SPI register block. It adds configurable widths and register count, read-back on CIPO, and framing-error detection. All SPI inputs are asynchronous to `clk` and are oversampled; outputs feed the PWM and output-enable logic directly.

## Interface
- `NUM_REGS`, 5: number of registers; addresses `0..NUM_REGS-1`.
- `ADDR_W`, 7: address field width; `NUM_REGS <= 2**ADDR_W`.
- `DATA_W`, 8: register and data field width.
- `SYNC_STAGES`, 2: synchroniser depth on `nCS`, `SCLK` and `COPI`; must be ≥ 2.
- `clk  in  1`: system clock.
- `rst  in  1`: asynchronous, active-high reset.
- `nCS  in  1`: chip select, active low, asynchronous.
- `SCLK  in  1`: SPI clock, asynchronous, idle low.
- `COPI  in  1`: controller-out data, asynchronous.
- `CIPO  out  1`: peripheral-out data.
- `cipo_oe  out  1`: CIPO output enable, high while synchronised `nCS` is low.
- `regs_out  out  NUM_REGS*DATA_W`: register `i` at bits `[i*DATA_W +: DATA_W]`.
- `wr_valid  out  1`: one-cycle pulse on the cycle a register is updated.
- `frame_err  out  1`: one-cycle pulse when a frame is rejected.

## Operation
- Frame format, MSB first: `rw` (1 = write, 0 = read), then `ADDR_W` address bits, then `DATA_W` data bits. `FRAME_W = 1 + ADDR_W + DATA_W`, which is 16 by default.
- COPI is sampled on the synchronised SCLK rising edge. CIPO changes on the synchronised SCLK falling edge.
- States:
  - IDLE → CMD on `nCS` fall; bit counter cleared.
  - CMD: shift `rw` and address bits. After bit `1+ADDR_W`, go to DATA. If `rw=0`, latch the read register into the tx shift register in the same cycle; an out-of-range address latches 0.
  - DATA: shift the data bits. For a read, the tx register's MSB drives CIPO from the next SCLK fall, then shifts left on each fall. CIPO is 0 outside DATA of a read.
  - Any state on `nCS` rise → DONE.
  - DONE (one cycle) → IDLE.
- DONE commit rules:
  - Bit count exactly `FRAME_W`, `rw=1`, address in range: write the data to the register and pulse `wr_valid`.
  - Bit count exactly `FRAME_W`, `rw=1`, address out of range: ignore silently; no `wr_valid`, no `frame_err`.
  - Bit count exactly `FRAME_W`, `rw=0`: no register change.
  - Bit count not equal to `FRAME_W`: pulse `frame_err`; no write. The counter saturates at `FRAME_W+1`, so over-long frames are rejected.
- Reset: all registers, `regs_out`, shift registers and counter go to 0; state goes to IDLE; `CIPO=0`, `cipo_oe=0`, `wr_valid=0`, `frame_err=0`.
- Reset asserted mid-frame drops the frame. If `nCS` is already low at reset release, no frame starts until the next `nCS` fall.
- `nCS` rise coinciding with an SCLK edge: the nCS event wins and that SCLK edge is not counted.

## Timing
- Edge detection uses `SYNC_STAGES` synchroniser flops plus one history flop per signal. An edge pulse is asserted `SYNC_STAGES+1` clk cycles after the pin transition.
- SCLK high and low phases must each be at least `SYNC_STAGES+2` clk periods. `nCS` setup to the first SCLK rise, and the last SCLK fall to `nCS` rise, must each be at least the same.
- Write latency: `regs_out` and `wr_valid` change on the clk edge that ends DONE. That is `SYNC_STAGES+2` cycles after the `nCS` pin rise.
- CIPO is valid `SYNC_STAGES+2` clk cycles after the SCLK pin fall. The controller samples it on the following SCLK rise.
- `regs_out` is registered and is stable except on commit cycles.

## Structure
- Package `spi_pkg`: state enum (IDLE, CMD, DATA, DONE), the rw encoding constants, and a `frame_w(ADDR_W, DATA_W)` function.
- Sub-module `spi_sync_edge` (parameter `SYNC_STAGES`): synchroniser plus rise/fall pulse outputs.
  - One instance each for `nCS` and `SCLK`.
  - `COPI` uses the synchronised output only.
- The register bank is a generate loop inside the top module.

## Test plan
- Write: send frame 0x8455 (write, addr 4, data 0x55) → reg 4 = 0x55, one `wr_valid` pulse, all other registers stay 0.
- Read: write 0x0A to reg 1, then send frame 0x0100 (read, addr 1) → CIPO returns 0x0A during the data phase; no register changes.
- Short frame: 15 bits, then `nCS` rise → `frame_err` pulse, no `wr_valid`, registers unchanged. Repeat with 17 bits → same response.
- Out of range: write to addr 0x7F → no change, no `wr_valid`, no `frame_err`. Read of addr 0x7F → CIPO is all zeros.
- Reset mid-frame: assert `rst` after 8 bits → all outputs 0 immediately. A following full frame written after a fresh `nCS` fall succeeds.
- Parameters: `NUM_REGS=16`, `ADDR_W=4`, `DATA_W=16`, `SYNC_STAGES=3` → 21-bit frame writing 0xBEEF to reg 15 reads back 0xBEEF.
